// File: rtl/ddf_tagged_flux_merger_pkg.sv
// Package shared by the tagged flux merger and its per-flux FIFO.
// Contents:
//   clog2_min1  - ceil(log2(n)) clamped to at least 1, so that one-entry
//                 cases (FLUX=1) still get a 1-bit tag / index field.
//   tag_width   - tag field width for a given flux count.
//   token_width - width of a {tag,data} token.
package ddf_tagged_flux_merger_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tag_width(input int flux);
        return clog2_min1(flux);
    endfunction

    function automatic int token_width(input int flux, input int data_width);
        return tag_width(flux) + data_width;
    endfunction

endpackage

// File: rtl/ddf_flux_fifo.sv
// Synchronous first-word-fall-through FIFO, one per flux.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   wr, din   - write strobe and data; ignored while full
//   rd        - pop strobe; ignored while empty
//   dout      - head entry, valid whenever empty=0
//   full      - count == DEPTH (registered count only)
//   empty     - count == 0
//   count     - current occupancy, 0..DEPTH
// DEPTH must be a power of two, so the pointers wrap by natural overflow.
module ddf_flux_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    rd,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A write at count==DEPTH is rejected even if a pop happens in the same
    // cycle; this keeps full free of any path from the read side.
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddf_tagged_flux_merger.sv
// Transmit side of the tagged multi-flux DDF input stream.
// FLUX untagged producer streams are each buffered in their own FIFO; a
// round-robin arbiter emits one {tag,data} token per cycle on a single
// write/full port, honouring per-flux back-pressure from downstream.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   src_write         - per-flux write strobe
//   src_datain        - per-flux payload, flux f at [f*DATA_WIDTH +: DATA_WIDTH]
//   src_full          - per-flux FIFO full; all ones while rst=1
//   out_port_write    - token write strobe to downstream
//   out_port_dataout  - {tag, data}, tag in the MSBs; holds last value when idle
//   out_port_full     - downstream full per flux, indexed by tag
//   err_overflow      - sticky per-flux flag: write attempted while full
//
// Handshake: a producer write on flux f is taken at the edge where
// src_write[f]=1 and src_full[f]=0. Downstream takes every token written in
// a cycle where out_port_full[tag]=0 in that same cycle; the merger only
// writes a tag whose full bit is low, so a written token is always accepted.
module ddf_tagged_flux_merger
    import ddf_tagged_flux_merger_pkg::*;
#(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [FLUX-1:0]                           src_write,
    input  logic [FLUX*DATA_WIDTH-1:0]                src_datain,
    output logic [FLUX-1:0]                           src_full,
    output logic                                      out_port_write,
    output logic [token_width(FLUX, DATA_WIDTH)-1:0]  out_port_dataout,
    input  logic [FLUX-1:0]                           out_port_full,
    output logic [FLUX-1:0]                           err_overflow
);

    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int WIDTH     = token_width(FLUX, DATA_WIDTH);
    localparam int CW        = $clog2(DEPTH) + 1;

    logic [FLUX-1:0]       fifo_full;
    logic [FLUX-1:0]       fifo_empty;
    logic [FLUX-1:0]       fifo_rd;
    logic [FLUX-1:0]       eligible;
    logic [DATA_WIDTH-1:0] head       [FLUX];
    logic [CW-1:0]         fifo_count [FLUX];

    logic [TAG_WIDTH-1:0]  rr_ptr;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic                  grant_valid;
    logic [WIDTH-1:0]      grant_token;
    logic [WIDTH-1:0]      last_token;

    for (genvar g = 0; g < FLUX; g++) begin : g_flux
        ddf_flux_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (src_write[g]),
            .din   (src_datain[g*DATA_WIDTH +: DATA_WIDTH]),
            .rd    (fifo_rd[g]),
            .dout  (head[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .count (fifo_count[g])
        );

        assign eligible[g] = (fifo_count[g] != '0) && !out_port_full[g];
        assign fifo_rd[g]  = out_port_write && (grant_idx == TAG_WIDTH'(g));

        // empty and count are two views of the same occupancy; they must agree.
        assert property (@(posedge clk) disable iff (rst)
                         fifo_empty[g] == (fifo_count[g] == '0));
    end

    // Round-robin search starting just after the last granted flux. A flux
    // that is blocked downstream is simply skipped, so it never stalls others.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= FLUX; k++) begin
            if (!grant_valid && eligible[(int'(rr_ptr) + k) % FLUX]) begin
                grant_valid = 1'b1;
                grant_idx   = TAG_WIDTH'((int'(rr_ptr) + k) % FLUX);
            end
        end
    end

    assign grant_token      = {grant_idx, head[grant_idx]};
    assign out_port_write   = grant_valid && !rst;
    assign out_port_dataout = out_port_write ? grant_token : last_token;
    assign src_full         = rst ? '1 : fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= TAG_WIDTH'(FLUX - 1);
            last_token   <= '0;
            err_overflow <= '0;
        end else begin
            if (out_port_write) begin
                rr_ptr     <= grant_idx;
                last_token <= grant_token;
            end
            err_overflow <= err_overflow | (src_write & fifo_full);
        end
    end

endmodule
